// File: rtl/wb_dram_arbiter_if.sv
// Pipelined Wishbone bundle shared by both arbiter masters and the DRAM-side slave port.
interface wb_dram_arbiter_if #(
  parameter int ADR_W = 28
);
  logic [ADR_W-1:0] adr;
  logic [31:0]      dat_w;
  logic [31:0]      dat_r;
  logic [3:0]       sel;
  logic             we;
  logic             cyc;
  logic             stb;
  logic             stall;
  logic             ack;
  logic             err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, stall, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, stall, ack, err
  );
endinterface

// File: rtl/wb_dram_arbiter.sv
// Two-master pipelined Wishbone arbiter in front of a DRAM user port, with
// alternating tie-break, outstanding-request tracking and a response watchdog.
module wb_dram_arbiter #(
  parameter int ADR_W   = 28,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  wb_dram_arbiter_if.slave   m0,
  wb_dram_arbiter_if.slave   m1,
  wb_dram_arbiter_if.master  s
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  state_e           state_q, state_d;
  logic             lastGnt_q, lastGnt_d;
  logic [3:0]       outst_q, outst_d;
  logic [9:0]       wdog_q, wdog_d;

  logic             gnt0, gnt1, granted;
  logic             full, issue, resp, counting, timeout;
  logic [ADR_W-1:0] selAdr;
  logic [31:0]      selDatW;
  logic [3:0]       selSel;
  logic             selWe, selCyc, selStb;

  // Reset gates the grant so a mid-transfer reset forwards nothing.
  assign gnt0    = (state_q == GNT0) && !rst;
  assign gnt1    = (state_q == GNT1) && !rst;
  assign granted = gnt0 || gnt1;

  assign full     = (outst_q == 4'd15);
  assign resp     = granted && (s.ack || s.err);
  assign counting = granted && (outst_q != 4'd0) && !s.ack && !s.err;
  assign timeout  = counting && ((wdog_q + 10'd1) == TIMEOUT_C);
  assign issue    = s.stb && !s.stall;

  always_comb begin
    selAdr  = gnt1 ? m1.adr   : m0.adr;
    selDatW = gnt1 ? m1.dat_w : m0.dat_w;
    selSel  = gnt1 ? m1.sel   : m0.sel;
    selWe   = gnt1 ? m1.we    : m0.we;
    selCyc  = (gnt0 && m0.cyc) || (gnt1 && m1.cyc);
    selStb  = (gnt0 && m0.stb) || (gnt1 && m1.stb);
  end

  // A full counter holds the strobe back so the slave never accepts a beat the master sees stalled.
  always_comb begin
    s.adr   = selAdr;
    s.dat_w = selDatW;
    s.sel   = selSel;
    s.we    = selWe;
    s.cyc   = selCyc && !timeout;
    s.stb   = selStb && !timeout && !full;

    m0.dat_r = gnt0 ? s.dat_r : 32'd0;
    m0.stall = gnt0 ? (s.stall || full || timeout) : m0.cyc;
    m0.ack   = gnt0 && s.ack;
    m0.err   = gnt0 && (s.err || timeout);

    m1.dat_r = gnt1 ? s.dat_r : 32'd0;
    m1.stall = gnt1 ? (s.stall || full || timeout) : m1.cyc;
    m1.ack   = gnt1 && s.ack;
    m1.err   = gnt1 && (s.err || timeout);
  end

  always_comb begin
    state_d   = state_q;
    lastGnt_d = lastGnt_q;
    outst_d   = outst_q;
    wdog_d    = 10'd0;

    case (state_q)
      IDLE: begin
        outst_d = 4'd0;
        if (m0.cyc && m1.cyc) begin
          state_d = lastGnt_q ? GNT0 : GNT1;
        end else if (m0.cyc) begin
          state_d = GNT0;
        end else if (m1.cyc) begin
          state_d = GNT1;
        end
      end

      GNT0, GNT1: begin
        if (!selCyc || timeout) begin
          state_d   = IDLE;
          lastGnt_d = (state_q == GNT1);
          outst_d   = 4'd0;
        end else begin
          if (issue && !resp && !full) begin
            outst_d = outst_q + 4'd1;
          end else if (resp && !issue && (outst_q != 4'd0)) begin
            outst_d = outst_q - 4'd1;
          end
          wdog_d = counting ? (wdog_q + 10'd1) : 10'd0;
        end
      end

      default: begin
        state_d = IDLE;
        outst_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
      outst_q   <= 4'd0;
      wdog_q    <= 10'd0;
    end else begin
      state_q   <= state_d;
      lastGnt_q <= lastGnt_d;
      outst_q   <= outst_d;
      wdog_q    <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_dram_arbiter.sv
// Directed bench for wb_dram_arbiter: a cycle-by-cycle vector table for arbitration,
// then hand-written sequences for pipelining, timeout, reset mid-burst and slave error.
module tb_wb_dram_arbiter;

  localparam int ADR_W   = 28;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_dram_arbiter_if #(.ADR_W(ADR_W)) m0if ();
  wb_dram_arbiter_if #(.ADR_W(ADR_W)) m1if ();
  wb_dram_arbiter_if #(.ADR_W(ADR_W)) sif ();

  wb_dram_arbiter #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0if),
    .m1  (m1if),
    .s   (sif)
  );

  int compared   = 0;
  int mismatched = 0;

  // in  = {rst, m0 cyc, m0 stb, m1 cyc, m1 stb, s stall, s ack, s err}
  // exp = {s cyc, s stb, m0 stall, m0 ack, m0 err, m1 stall, m1 ack, m1 err}
  // gnt = master whose address/data must appear on the slave port (0 = unchecked)
  typedef struct {
    logic [7:0] in;
    logic [1:0] gnt;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mkVec(input logic [7:0] in, input logic [1:0] gnt, input logic [7:0] exp);
    vec_t v;
    v.in  = in;
    v.gnt = gnt;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outBits();
    return {sif.cyc, sif.stb, m0if.stall, m0if.ack, m0if.err, m1if.stall, m1if.ack, m1if.err};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] in);
    {rst, m0if.cyc, m0if.stb, m1if.cyc, m1if.stb, sif.stall, sif.ack, sif.err} = in;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive after the edge, compare the output bundle on the falling edge.
  task automatic stepCheck(input string name, input logic [7:0] in, input logic [7:0] exp);
    nextCycle();
    applyStimulus(in);
    @(negedge clk);
    checkOutput(name, 32'(outBits()), 32'(exp));
  endtask

  initial begin
    m0if.adr   = 28'h100;
    m0if.dat_w = 32'hDEADBEEF;
    m0if.sel   = 4'hF;
    m0if.we    = 1'b1;
    m1if.adr   = 28'h200;
    m1if.dat_w = 32'h12345678;
    m1if.sel   = 4'h3;
    m1if.we    = 1'b0;
    sif.dat_r  = 32'd0;
    applyStimulus(8'b1_00_00_000);

    tbl[0]  = mkVec(8'b1_10_10_000, 2'd0, 8'b00_100_100);
    tbl[1]  = mkVec(8'b0_11_10_000, 2'd0, 8'b00_100_100);
    tbl[2]  = mkVec(8'b0_11_10_000, 2'd1, 8'b11_000_100);
    tbl[3]  = mkVec(8'b0_10_10_010, 2'd1, 8'b10_010_100);
    tbl[4]  = mkVec(8'b0_00_11_000, 2'd0, 8'b00_000_100);
    tbl[5]  = mkVec(8'b0_00_11_000, 2'd0, 8'b00_000_100);
    tbl[6]  = mkVec(8'b0_10_11_100, 2'd2, 8'b11_100_100);
    tbl[7]  = mkVec(8'b0_10_11_000, 2'd2, 8'b11_100_000);
    tbl[8]  = mkVec(8'b0_10_00_010, 2'd0, 8'b00_100_010);
    tbl[9]  = mkVec(8'b0_10_00_010, 2'd0, 8'b00_100_000);
    tbl[10] = mkVec(8'b0_10_00_000, 2'd1, 8'b10_000_000);
    tbl[11] = mkVec(8'b0_00_00_000, 2'd0, 8'b00_000_000);
    tbl[12] = mkVec(8'b0_10_10_000, 2'd0, 8'b00_100_100);
    tbl[13] = mkVec(8'b0_10_10_000, 2'd2, 8'b10_100_000);
    tbl[14] = mkVec(8'b0_10_00_000, 2'd0, 8'b00_100_000);
    tbl[15] = mkVec(8'b0_10_10_000, 2'd0, 8'b00_100_100);
    tbl[16] = mkVec(8'b0_10_10_000, 2'd1, 8'b10_000_100);
    tbl[17] = mkVec(8'b0_00_00_010, 2'd0, 8'b00_010_000);
    tbl[18] = mkVec(8'b0_00_00_010, 2'd0, 8'b00_000_000);

    for (int i = 0; i < 19; i++) begin
      nextCycle();
      applyStimulus(tbl[i].in);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), 32'(outBits()), 32'(tbl[i].exp));
      if (tbl[i].gnt != 2'd0) begin
        checkOutput($sformatf("vec%0d_adr", i), 32'(sif.adr),
                    (tbl[i].gnt == 2'd1) ? 32'h100 : 32'h200);
        checkOutput($sformatf("vec%0d_dat_w", i), sif.dat_w,
                    (tbl[i].gnt == 2'd1) ? 32'hDEADBEEF : 32'h12345678);
      end
    end

    // m1 issues four reads back to back, responses come back afterwards in order
    stepCheck("pipe_req", 8'b0_00_11_000, 8'b00_000_100);
    for (int i = 0; i < 4; i++) begin
      stepCheck($sformatf("pipe_issue%0d", i), 8'b0_00_11_000, 8'b11_000_000);
    end
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      applyStimulus(8'b0_00_10_010);
      sif.dat_r = 32'hA0000000 + 32'(i);
      @(negedge clk);
      if (i == 0) checkOutput("pipe_peak", 32'(dut.outst_q), 32'd4);
      checkOutput($sformatf("pipe_ack%0d", i), 32'(outBits()), 32'(8'b10_000_010));
      checkOutput($sformatf("pipe_dat_r%0d", i), m1if.dat_r, 32'hA0000000 + 32'(i));
      checkOutput($sformatf("pipe_m0_dat_r%0d", i), m0if.dat_r, 32'd0);
    end
    nextCycle();
    applyStimulus(8'b0_00_00_000);
    sif.dat_r = 32'd0;
    @(negedge clk);
    checkOutput("pipe_drained", 32'(dut.outst_q), 32'd0);
    checkOutput("pipe_release", 32'(outBits()), 32'd0);

    // m0 issues one beat that is never answered
    stepCheck("to_req", 8'b0_11_00_000, 8'b00_100_000);
    stepCheck("to_issue", 8'b0_11_00_000, 8'b11_000_000);
    for (int k = 1; k <= TIMEOUT; k++) begin
      stepCheck($sformatf("to_wait%0d", k), 8'b0_10_00_000,
                (k == TIMEOUT) ? 8'b00_101_000 : 8'b10_000_000);
    end
    stepCheck("to_idle", 8'b0_10_00_000, 8'b00_100_000);
    @(negedge clk);
    checkOutput("to_outst", 32'(dut.outst_q), 32'd0);
    stepCheck("to_regrant_drop", 8'b0_00_00_000, 8'b00_000_000);

    // reset lands with two beats outstanding; the following response is dropped
    stepCheck("rst_req", 8'b0_11_00_000, 8'b00_100_000);
    stepCheck("rst_issue1", 8'b0_11_00_000, 8'b11_000_000);
    stepCheck("rst_issue2", 8'b0_11_00_000, 8'b11_000_000);
    stepCheck("rst_pulse", 8'b1_10_00_010, 8'b00_100_000);
    checkOutput("rst_outst_before", 32'(dut.outst_q), 32'd2);
    stepCheck("rst_late_ack", 8'b0_00_00_010, 8'b00_000_000);
    checkOutput("rst_outst_after", 32'(dut.outst_q), 32'd0);
    checkOutput("rst_wdog_after", 32'(dut.wdog_q), 32'd0);

    // three writes from m0, the second answered with err
    stepCheck("err_req", 8'b0_11_00_000, 8'b00_100_000);
    stepCheck("err_issue1", 8'b0_11_00_000, 8'b11_000_000);
    stepCheck("err_issue2", 8'b0_11_00_000, 8'b11_000_000);
    stepCheck("err_issue3_ack1", 8'b0_11_00_010, 8'b11_010_000);
    stepCheck("err_beat2", 8'b0_10_00_001, 8'b10_001_000);
    checkOutput("err_outst_before", 32'(dut.outst_q), 32'd2);
    stepCheck("err_ack3", 8'b0_10_00_010, 8'b10_010_000);
    checkOutput("err_outst_mid", 32'(dut.outst_q), 32'd1);
    stepCheck("err_release", 8'b0_00_00_000, 8'b00_000_000);
    checkOutput("err_outst_end", 32'(dut.outst_q), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
